wb_arbiter: RTL
===============

Name: wb_arbiter

Overview:
- Writeback arbiter that drives the physical register file's two write ports.
- Accepts completed results (physical tag plus data) from NSRC functional units over valid/ready handshakes, and buffers each source in a small FIFO.
- Each cycle, grants up to two sources round-robin and registers them onto write port 0 and write port 1.
- Sits between the execute units (ALU0, ALU1, LSU, BRU) and the PRF. The registered wen/wtag outputs also serve as the wakeup broadcast to the issue queue.

Parameters:
- XLEN, core_pkg::XLEN, data width.
- PREGS, core_pkg::PREGS, number of physical registers; tags are core_pkg::preg_tag_t.
- NSRC, 4, number of writeback sources (must be ≥2).
- FIFO_DEPTH, 2, entries per source FIFO (power of two, ≥1).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline flush.
- src_valid  in  NSRC  per-source result valid.
- src_ready  out  NSRC  per-source FIFO can accept.
- src_tag  in  NSRC x preg_tag_t  destination physical tag per source.
- src_data  in  NSRC x XLEN  result data per source.
- wen0  out  1  PRF write port 0 enable (registered).
- wtag0  out  preg_tag_t  PRF write port 0 tag.
- wdata0  out  XLEN  PRF write port 0 data.
- wen1  out  1  PRF write port 1 enable (registered).
- wtag1  out  preg_tag_t  PRF write port 1 tag.
- wdata1  out  XLEN  PRF write port 1 data.

Behaviour:
- Reset (reset_n low, asynchronous)
  - All FIFOs empty and rr_ptr = 0.
  - wen0 = wen1 = 0; wtag0/1 = 0; wdata0/1 = 0.
  - src_ready is forced 0 while reset_n is low.
  - A reset mid-operation discards all buffered results.
- Enqueue
  - src_ready[i] = (count[i] < FIFO_DEPTH) and not flush. This is combinational from registered state only; it does not depend on the same-cycle grant.
  - A transfer occurs when src_valid[i] && src_ready[i]; the entry is written at the rising edge.
  - src_valid with src_ready low: the source must hold tag/data stable; nothing is captured.
- Arbitration (combinational over FIFO heads, registered outputs)
  - Candidates are the sources with a non-empty FIFO.
  - Scan from index rr_ptr upward, modulo NSRC.
  - The first candidate found is g0 and goes to port 0; the second distinct candidate is g1 and goes to port 1.
  - With zero candidates, neither port is granted. With one candidate, only port 0 is granted.
  - Granted heads are dequeued at the edge. The same edge sets {wen0,wtag0,wdata0} and {wen1,wtag1,wdata1}. An ungranted port gets wen=0, and its wtag/wdata hold their previous values.
  - A source enqueuing and being dequeued in the same cycle keeps count unchanged. A full FIFO that is dequeued this cycle still shows src_ready=0 this cycle.
- rr_ptr update
  - After any grant, rr_ptr <= (index of last granted source + 1) mod NSRC.
  - With no grant, rr_ptr is unchanged.
  - Wrap: with NSRC=4, a grant of g1=3 sets rr_ptr to 0.
- Latency
  - A source accepted in cycle N appears on wen in cycle N+2 at the earliest: visible as head in N+1, registered at the end of N+1.
  - No FIFO-empty bypass.
- Ordering
  - Per source, results are written in enqueue order.
  - No ordering is guaranteed across sources.
- Tag collisions
  - Distinct sources carrying the same tag is a rename error and is not checked.
  - Both ports may carry that tag; the PRF gives port 0 priority.
- Flush (synchronous)
  - All FIFOs are cleared and rr_ptr <= 0.
  - Enqueues in the flush cycle are dropped.
  - wen0/wen1 <= 0 at that edge; any grant that would have occurred in the flush cycle is discarded.
- Throughput
  - Sustained 2 writes per cycle when at least 2 sources are non-empty.
  - Each source gets at most 1 write per cycle.

Optional Feature:
- Macro: WB_STATS_EN.
- With the macro defined:
  - Adds output stall_cnt (32 bits), which increments each cycle in which any src_valid[i] && !src_ready[i] holds.
  - Adds output drop_cnt (32 bits), which increments by the number of FIFO entries discarded on flush.
  - Both counters reset to 0 on reset_n only (not on flush) and saturate at all-ones.
- Without the macro: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single result, otherwise idle
  - Stimulus: reset, then one cycle of src_valid=0001 with tag 5, data 0xA5 at cycle N.
  - Required: wen0=1, wtag0=5, wdata0=0xA5 in cycle N+2; wen1=0; rr_ptr becomes 1.
- Four simultaneous results
  - Stimulus: src_valid=1111 for one cycle with tags 1,2,3,4.
  - Required: next-cycle grants to sources 0 and 1, giving (wtag0,wtag1)=(1,2); the following cycle gives (3,4); rr_ptr becomes 0.
- Backpressure on one source
  - Stimulus: hold src_valid[2]=1 for 4 consecutive cycles while the other sources keep the arbiter busy.
  - Required: src_ready[2] drops to 0 once count=2; no entry is lost or duplicated; all 4 tags appear in order on the ports.
- Round-robin fairness
  - Stimulus: all 4 sources continuously valid for 8 cycles.
  - Required: each source is granted exactly 4 times; grant pairs rotate (0,1),(2,3),(0,1),…
- Flush with entries buffered
  - Stimulus: 3 FIFOs non-empty, assert flush for one cycle.
  - Required: wen0=wen1=0 the next cycle and nothing further is written; src_ready=0 during the flush cycle, then 1; with WB_STATS_EN, drop_cnt increases by the number of buffered entries.
- Asynchronous reset mid-burst
  - Stimulus: pull reset_n low between clock edges.
  - Required: wen0/wen1 go to 0 immediately and src_ready goes to 0; after release, the first grant starts from source 0.

Source files
------------

// File: rtl/core_pkg.sv
// Core-wide widths and the writeback payload type shared by the arbiter and its bus.
package core_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned PREGS  = 64;
    localparam int unsigned PTAG_W = $clog2(PREGS);

    typedef logic [PTAG_W-1:0] preg_tag_t;

    // One buffered writeback result: destination physical tag plus data.
    typedef struct packed {
        preg_tag_t         tag;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus: per-source result handshakes in, two PRF write ports out.
interface wb_arbiter_if #(
    parameter int unsigned NSRC = 4
) ();
    import core_pkg::*;

    logic [NSRC-1:0]  src_valid;
    logic [NSRC-1:0]  src_ready;
    preg_tag_t        src_tag  [NSRC];
    logic [XLEN-1:0]  src_data [NSRC];

    logic             wen0;
    preg_tag_t        wtag0;
    logic [XLEN-1:0]  wdata0;
    logic             wen1;
    preg_tag_t        wtag1;
    logic [XLEN-1:0]  wdata1;

    // Execute-unit side: offers results, observes the write ports.
    modport master (
        output src_valid, src_tag, src_data,
        input  src_ready, wen0, wtag0, wdata0, wen1, wtag1, wdata1
    );

    // Arbiter side.
    modport slave (
        input  src_valid, src_tag, src_data,
        output src_ready, wen0, wtag0, wdata0, wen1, wtag1, wdata1
    );

endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-source FIFOs, round-robin grant of up to two heads per
// cycle onto the two PRF write ports. Optional statistics counters are enabled
// with the WB_STATS_EN macro (adds stall_cnt and drop_cnt outputs).
module wb_arbiter
    import core_pkg::*;
#(
    parameter int unsigned NSRC       = 4,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    wb_arbiter_if.slave bus
`ifdef WB_STATS_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] drop_cnt
`endif
);

    localparam int unsigned IDX_W = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    wb_entry_t         mem    [NSRC][FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr [NSRC];
    logic [PTR_W-1:0]  wr_ptr [NSRC];
    logic [CNT_W-1:0]  count  [NSRC];
    logic [IDX_W-1:0]  rr_ptr;

    logic [NSRC-1:0]   ready_c;
    logic [NSRC-1:0]   enq;
    logic [NSRC-1:0]   deq;
    logic              gv0;
    logic              gv1;
    logic [IDX_W-1:0]  g0;
    logic [IDX_W-1:0]  g1;
    wb_entry_t         head0;
    wb_entry_t         head1;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == FIFO_DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] g);
        return (32'(g) == NSRC - 1) ? '0 : g + IDX_W'(1);
    endfunction

    // Acceptance depends only on registered occupancy, never on this cycle's grant.
    always_comb begin
        ready_c = '0;
        enq     = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            ready_c[i] = reset_n && (count[i] < CNT_W'(FIFO_DEPTH)) && !flush;
            enq[i]     = bus.src_valid[i] && ready_c[i];
        end
    end

    assign bus.src_ready = ready_c;

    // Round-robin scan from rr_ptr: first non-empty source to port 0, second to port 1.
    always_comb begin
        int unsigned idx;
        idx = 0;
        gv0 = 1'b0;
        gv1 = 1'b0;
        g0  = '0;
        g1  = '0;
        for (int unsigned k = 0; k < NSRC; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NSRC) idx = idx - NSRC;
            if (count[IDX_W'(idx)] != '0) begin
                if (!gv0) begin
                    gv0 = 1'b1;
                    g0  = IDX_W'(idx);
                end else if (!gv1) begin
                    gv1 = 1'b1;
                    g1  = IDX_W'(idx);
                end
            end
        end
    end

    // Dequeue strobes for the granted heads.
    always_comb begin
        deq = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            deq[i] = (gv0 && (g0 == IDX_W'(i))) || (gv1 && (g1 == IDX_W'(i)));
        end
    end

    assign head0 = mem[g0][rd_ptr[g0]];
    assign head1 = mem[g1][rd_ptr[g1]];

    // FIFO pointers and occupancy; flush and reset both empty every FIFO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NSRC; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else if (flush) begin
            for (int unsigned i = 0; i < NSRC; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NSRC; i++) begin
                if (enq[i]) wr_ptr[i] <= ptr_inc(wr_ptr[i]);
                if (deq[i]) rd_ptr[i] <= ptr_inc(rd_ptr[i]);
                count[i] <= count[i] + CNT_W'(enq[i]) - CNT_W'(deq[i]);
            end
        end
    end

    // FIFO storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (enq[i]) mem[i][wr_ptr[i]] <= '{tag: bus.src_tag[i], data: bus.src_data[i]};
        end
    end

    // Registered write ports and round-robin pointer; ungranted ports hold tag/data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.wen0   <= 1'b0;
            bus.wtag0  <= '0;
            bus.wdata0 <= '0;
            bus.wen1   <= 1'b0;
            bus.wtag1  <= '0;
            bus.wdata1 <= '0;
            rr_ptr     <= '0;
        end else if (flush) begin
            bus.wen0   <= 1'b0;
            bus.wen1   <= 1'b0;
            rr_ptr     <= '0;
        end else begin
            bus.wen0 <= gv0;
            bus.wen1 <= gv1;
            if (gv0) begin
                bus.wtag0  <= head0.tag;
                bus.wdata0 <= head0.data;
            end
            if (gv1) begin
                bus.wtag1  <= head1.tag;
                bus.wdata1 <= head1.data;
            end
            if (gv1)      rr_ptr <= idx_inc(g1);
            else if (gv0) rr_ptr <= idx_inc(g0);
        end
    end

`ifdef WB_STATS_EN
    logic        stall_any;
    logic [31:0] flushed;
    logic [32:0] drop_sum;

    // Stall detection and number of entries a flush would discard.
    always_comb begin
        stall_any = |(bus.src_valid & ~ready_c);
        flushed   = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            flushed = flushed + 32'(count[i]);
        end
        drop_sum = {1'b0, drop_cnt} + 33'(flushed);
    end

    // Saturating statistics; only reset_n clears them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (stall_any && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
            if (flush) drop_cnt <= drop_sum[32] ? '1 : drop_sum[31:0];
        end
    end
`endif

endmodule
